trans_seq: RTL and testbench
============================

# trans_seq

Frame sequencer for the sign-magnitude to two's-complement converter stage ahead of the FFT. On a start pulse it reads one frame of samples from the synchronous sample RAM and presents each magnitude and sign to the converter. The sign is skewed one cycle behind its magnitude to match the converter's internal pipeline. It regenerates valid, last and index sideband aligned with the converter's 12-bit output, so the FFT input buffer sees a clean framed stream.

## Interface
- FRAME_LEN, 1024: samples per frame; range 2..2^ADDR_W.
- ADDR_W, 10: sample RAM address width.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle frame request; honoured only in IDLE.
- abort  in  1  cancels the frame in progress.
- base_addr  in  ADDR_W  first RAM address; captured on an accepted start.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  11  RAM word {sign, mag[9:0]}; valid the cycle after rd_en.
- conv_mag  out  10  to converter magnitude input; registered.
- conv_qsub  out  11  to converter sign input; {sign, 10'b0}; registered.
- conv_data  in  12  converter output.
- out_data  out  12  conv_data passthrough.
- out_valid  out  1  out_data holds a frame sample.
- out_last  out  1  final sample of the frame.
- out_idx  out  ADDR_W  sample index 0..FRAME_LEN-1 within the frame.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse with the final output.

## Operation
- States:
  - IDLE: start -> READ.
  - READ: rd_en=1 for FRAME_LEN consecutive cycles; after the last read -> DRAIN.
  - DRAIN: waits 4 cycles for the pipeline to empty -> IDLE.
- Address:
  - rd_addr = base_addr + n, with n the read count.
  - Wraps modulo 2^ADDR_W; 1023 + 1 = 0 for ADDR_W=10.
- Per sample, relative to its rd_en cycle c:
  - rd_data arrives at c+1.
  - conv_mag is registered and driven at c+2.
  - The sign bit passes through two registers, so conv_qsub = {sign, 10'b0} is driven at c+3. This matches the converter latching its magnitude one edge before it samples the sign.
  - The converter output is valid at c+4.
- Sideband: a 4-stage shift register carries {valid, last, idx} from rd_en to out_valid/out_last/out_idx.
- Registering: all controller outputs except out_data are registered. out_data is combinational from conv_data.
- Restart: start is ignored while busy; no queueing.
- abort:
  - In READ or DRAIN, the next state is IDLE and rd_en is deasserted the following cycle.
  - The sideband pipeline is cleared, so out_valid is 0 from the cycle after abort. frame_done does not pulse.
  - In IDLE, abort has no effect.
- start and abort in the same IDLE cycle: abort wins and the frame is not started.
- rst in mid-frame: same effect as abort, plus every register is cleared.
- Converter reset wiring: the converter's own reset is wired from !rst at the top level.

## Timing
- Reset values: every output is 0. out_data equals conv_data, which is 0 once the converter is held in reset.
- start accepted at cycle 0:
  - busy=1 and rd_en=1 (rd_addr=base_addr) from cycle 1.
  - Last read at cycle FRAME_LEN.
  - First out_valid at cycle 5; last at cycle FRAME_LEN+4, with out_last and frame_done asserted in that same cycle.
  - busy falls at cycle FRAME_LEN+5.
- Throughput: one sample per cycle, no bubbles. A new start is accepted in the cycle busy is 0, giving a 5-cycle gap between frames.
- Backpressure: none; the downstream consumer must accept every out_valid cycle.

## Structure
- Shared package holds:
  - the state encoding (IDLE, READ, DRAIN);
  - the SEQ_LAT=4 pipeline depth;
  - the sample word layout constants (SIGN_BIT=10, MAG_W=10, OUT_W=12).
- Natural sub-module: trans_align, the 4-deep sideband shift register with synchronous clear, reused for the sign skew.
- The converter is instantiated beside trans_seq at the top level, not inside it.

## Test plan
- FRAME_LEN=8, base 0, RAM[k] = {k[0], 10'd(k+1)}, with the behavioural converter model:
  - out_valid cycles 5..12;
  - out_data = +2, -4, +6, -8, ... (12'h002, 12'hFFC, 12'h006, 12'hFF8, ...);
  - out_idx 0..7;
  - out_last and frame_done only at cycle 12.
- Wrap: base_addr=1020, FRAME_LEN=8 -> rd_addr sequence 1020..1023, 0..3.
- abort at cycle 4 of a FRAME_LEN=8 frame:
  - rd_en=0 from cycle 5; out_valid never asserts; no frame_done; busy=0 at cycle 5.
  - A fresh start then completes normally.
- start pulsed at cycles 0 and 3:
  - the second start is ignored; exactly 8 outputs;
  - a start at cycle FRAME_LEN+5 is accepted.
- Sign skew: alternating sign with constant magnitude 10'h3FF -> out_data alternates between 12'h7FE and 12'h802, with no cross-sample sign error.
- rst asserted mid-DRAIN -> all outputs 0 the next cycle, IDLE, no frame_done.

Source files
------------

// File: rtl/trans_seq_pkg.sv
// rtl/trans_seq_pkg.sv - shared state encoding, pipeline depth and sample word layout
package trans_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int SEQ_LAT  = 4;
  localparam int SIGN_BIT = 10;
  localparam int MAG_W    = 10;
  localparam int OUT_W    = 12;

endpackage

// File: rtl/trans_align.sv
// rtl/trans_align.sv - fixed-depth shift register with synchronous clear
module trans_align #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/trans_seq.sv
// rtl/trans_seq.sv - frame sequencer feeding the sign-magnitude converter
// with sign skew and regenerated valid/last/index sideband.
module trans_seq
  import trans_seq_pkg::*;
#(
  parameter int FRAME_LEN = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [MAG_W:0]    rd_data,
  output logic [MAG_W-1:0]  conv_mag,
  output logic [MAG_W:0]    conv_qsub,
  input  logic [OUT_W-1:0]  conv_data,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [ADDR_W-1:0] out_idx,
  output logic              busy,
  output logic              frame_done
);

  localparam int SB_W = ADDR_W + 2;
  localparam logic [ADDR_W-1:0] LAST_N  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] DRAIN_N = ADDR_W'(SEQ_LAT - 1);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_rd_en, r_rd_vld, r_busy;
  logic [MAG_W-1:0]  r_mag;
  logic              w_abort, w_clr, w_sign;
  logic [SB_W-1:0]   w_sb_in, w_sb_out;

  assign w_abort = abort && (r_state != ST_IDLE);
  assign w_clr   = rst || w_abort;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start && !abort) w_next = ST_READ;
      ST_READ:  if (abort) w_next = ST_IDLE;
                else if (r_cnt == LAST_N) w_next = ST_DRAIN;
      ST_DRAIN: if (abort || r_cnt == DRAIN_N) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // r_cnt is the read index while reading and the drain count while draining.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_addr_nxt = r_addr;
    case (r_state)
      ST_IDLE: if (w_next == ST_READ) begin
        w_cnt_nxt  = '0;
        w_addr_nxt = base_addr;
      end
      ST_READ: if (w_next == ST_READ) begin
        w_cnt_nxt  = r_cnt + 1'b1;
        w_addr_nxt = r_addr + 1'b1;
      end else begin
        w_cnt_nxt  = '0;
      end
      ST_DRAIN: w_cnt_nxt = r_cnt + 1'b1;
      default:  w_cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_rd_en  <= 1'b0;
      r_rd_vld <= 1'b0;
      r_busy   <= 1'b0;
      r_mag    <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_addr   <= w_addr_nxt;
      r_rd_en  <= (w_next == ST_READ);
      r_rd_vld <= r_rd_en && !w_abort;
      r_busy   <= (w_next != ST_IDLE);
      r_mag    <= (r_rd_vld && !w_abort) ? rd_data[MAG_W-1:0] : '0;
    end
  end

  // Sign trails its magnitude by one cycle: the converter latches magnitude first.
  trans_align #(.W(1), .DEPTH(2)) u_sign_skew (
    .clk    (clk),
    .i_clr  (w_clr),
    .i_data (r_rd_vld & rd_data[SIGN_BIT]),
    .o_data (w_sign)
  );

  assign w_sb_in = {r_rd_en, r_rd_en && (r_cnt == LAST_N), r_rd_en ? r_cnt : '0};

  trans_align #(.W(SB_W), .DEPTH(SEQ_LAT)) u_sideband (
    .clk    (clk),
    .i_clr  (w_clr),
    .i_data (w_sb_in),
    .o_data (w_sb_out)
  );

  assign rd_en      = r_rd_en;
  assign rd_addr    = r_addr;
  assign busy       = r_busy;
  assign conv_mag   = r_mag;
  assign conv_qsub  = {w_sign, {MAG_W{1'b0}}};
  assign out_data   = conv_data;
  assign out_valid  = w_sb_out[SB_W-1];
  assign out_last   = w_sb_out[SB_W-2];
  assign frame_done = w_sb_out[SB_W-2];
  assign out_idx    = w_sb_out[ADDR_W-1:0];

endmodule

// File: tb/tb_trans_seq.sv
// tb/tb_trans_seq.sv - directed bench for trans_seq with sample RAM and converter models
module tb_trans_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [10:0] rd_data = '0;
  logic [9:0]  conv_mag;
  logic [10:0] conv_qsub;
  logic [11:0] conv_data;
  logic [11:0] out_data;
  logic        out_valid, out_last, busy, frame_done;
  logic [9:0]  out_idx;

  logic [10:0] ram [1024];
  logic        conv_rstn;
  logic [9:0]  cm;
  logic [11:0] co;
  logic [11:0] mag2;
  logic [11:0] exp_data [8];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_out;

  always #5 clk = ~clk;

  trans_seq #(.FRAME_LEN(8), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .conv_mag(conv_mag), .conv_qsub(conv_qsub), .conv_data(conv_data),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_idx(out_idx), .busy(busy), .frame_done(frame_done)
  );

  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  // Converter: latches magnitude, then applies the sign one edge later; output = +/-2*mag.
  assign conv_rstn = !rst;
  assign mag2      = {1'b0, cm, 1'b0};
  always @(posedge clk) begin
    if (!conv_rstn) begin
      cm <= '0;
      co <= '0;
    end else begin
      cm <= conv_mag;
      co <= conv_qsub[10] ? (~mag2 + 12'd1) : mag2;
    end
  end
  assign conv_data = co;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, 32'(rd_en), 0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 0);
    check({tag, "_conv_mag"}, 32'(conv_mag), 0);
    check({tag, "_conv_qsub"}, 32'(conv_qsub), 0);
    check({tag, "_out_data"}, 32'(out_data), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_last"}, 32'(out_last), 0);
    check({tag, "_out_idx"}, 32'(out_idx), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
  endtask

  // Called in an idle cycle (cycle 0); returns in cycle 15.
  task automatic run_frame(input string tag, input logic [9:0] base, input bit chk_data);
    logic [9:0] a;
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      a = 10'(32'(base) + c - 1);
      check({tag, "_busy"}, 32'(busy), 32'(c <= 12));
      check({tag, "_rd_en"}, 32'(rd_en), 32'(c <= 8));
      if (c <= 8) check({tag, "_rd_addr"}, 32'(rd_addr), 32'(a));
      check({tag, "_out_valid"}, 32'(out_valid), 32'(c >= 5 && c <= 12));
      check({tag, "_out_last"}, 32'(out_last), 32'(c == 12));
      check({tag, "_frame_done"}, 32'(frame_done), 32'(c == 12));
      if (c >= 5 && c <= 12) begin
        check({tag, "_out_idx"}, 32'(out_idx), 32'(c - 5));
        if (chk_data) check({tag, "_out_data"}, 32'(out_data), 32'(exp_data[c-5]));
      end
      tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_idle_timeout"}, 32'(busy), 0);
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) ram[k] = {k[0], 10'(k + 1)};
    exp_data = '{12'h002, 12'hFFC, 12'h006, 12'hFF8, 12'h00A, 12'hFF4, 12'h00E, 12'hFF0};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Main frame, plus direct look at the skewed converter inputs
    base_addr = 10'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mag_c3", 32'(conv_mag), 32'd1);
    tick();
    check("qsub_c4", 32'(conv_qsub), 32'h000);
    tick();
    check("qsub_c5", 32'(conv_qsub), 32'h400);
    wait_idle("main_pre");
    tick();
    run_frame("frame", 10'd0, 1'b1);

    // Address wrap
    run_frame("wrap", 10'd1020, 1'b0);

    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("startabort_busy", 32'(busy), 0);
    check("startabort_rd_en", 32'(rd_en), 0);
    tick();

    // Abort at cycle 4
    base_addr = 10'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_rd_en", 32'(rd_en), 0);
    check("abort_busy", 32'(busy), 0);
    for (int c = 5; c <= 14; c++) begin
      check("abort_out_valid", 32'(out_valid), 0);
      check("abort_frame_done", 32'(frame_done), 0);
      tick();
    end
    run_frame("after_abort", 10'd0, 1'b1);

    // Second start mid-frame ignored; start at cycle FRAME_LEN+5 accepted
    base_addr = 10'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_out = 0;
    for (int c = 1; c <= 13; c++) begin
      if (out_valid) n_out++;
      start = (c == 3) || (c == 13);
      if (c == 13) check("restart_c13_busy", 32'(busy), 0);
      tick();
    end
    start = 1'b0;
    check("double_start_outputs", 32'(n_out), 32'd8);
    check("restart_busy", 32'(busy), 1);
    check("restart_rd_addr", 32'(rd_addr), 0);
    wait_idle("restart");
    tick();

    // Sign skew with full-scale magnitude
    for (int k = 0; k < 8; k++) ram[k] = {k[0], 10'h3FF};
    exp_data = '{12'h7FE, 12'h802, 12'h7FE, 12'h802, 12'h7FE, 12'h802, 12'h7FE, 12'h802};
    run_frame("skew", 10'd0, 1'b1);

    // rst during DRAIN (cycle 10)
    base_addr = 10'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    check("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    for (int c = 12; c <= 14; c++) begin
      tick();
      check("midrst_frame_done", 32'(frame_done), 0);
      check("midrst_out_valid", 32'(out_valid), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
